flag_branch_unit: RTL and testbench

- Consumer end of the 16-bit ALU result/flag interface.
- Captures the ALU's ov/zr outputs plus a sign bit derived from dst into a condition-code register (Z, V, N), gated per opcode.
- Resolves 3-bit branch condition codes against that register through a registered request/response handshake.
- Sits between EX (ALU) and the fetch/PC-select logic, and keeps a taken-branch statistics counter.

---
 rtl/flag_branch_unit.sv | 118 +++++++++++
 tb/tb_flag_branch_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/flag_branch_unit.sv
// Condition-code register (Z,V,N) fed by the ALU, plus a request/response branch resolver
// with a wrapping taken-branch counter.
module flag_branch_unit #(
    parameter bit          FWD   = 1'b1,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alu_valid,
    input  logic [2:0]       alu_ops,
    input  logic [15:0]      alu_dst,
    input  logic             alu_ov,
    input  logic             alu_zr,
    input  logic             br_req,
    input  logic [2:0]       br_ccc,
    output logic             br_ready,
    output logic             br_done,
    output logic             br_taken,
    output logic [2:0]       flags,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [0:0] {StIdle, StResolve} state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [2:0]       r_flags;
    logic [2:0]       w_flags_nxt;
    logic [2:0]       w_flags_eval;
    logic             r_taken;
    logic             w_taken_nxt;
    logic             w_cond;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_unused_dst;

    // Only the sign bit of the result matters; zero detection comes from alu_zr.
    assign w_unused_dst = ^alu_dst[14:0];

    // Flag bit order is {Z, V, N}.
    function automatic logic f_cond(input logic [2:0] f, input logic [2:0] ccc);
        logic z;
        logic v;
        logic n;
        logic res;
        z = f[2];
        v = f[1];
        n = f[0];
        case (ccc)
            3'b000:  res = ~z;
            3'b001:  res = z;
            3'b010:  res = ~z & ~n;
            3'b011:  res = n;
            3'b100:  res = z | ~n;
            3'b101:  res = n | z;
            3'b110:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    always_comb begin
        w_flags_nxt = r_flags;
        if (alu_valid) begin
            case (alu_ops)
                3'b000, 3'b001: w_flags_nxt = {alu_zr, alu_ov, alu_dst[15]};
                3'b110:         w_flags_nxt = r_flags;
                default:        w_flags_nxt[2] = alu_zr;
            endcase
        end
    end

    // With forwarding, a branch sees the flags being written in the same cycle.
    assign w_flags_eval = FWD ? w_flags_nxt : r_flags;
    assign w_cond       = f_cond(w_flags_eval, br_ccc);

    always_comb begin
        w_state_nxt = r_state;
        w_taken_nxt = r_taken;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle: begin
                if (br_req) begin
                    w_state_nxt = StResolve;
                    w_taken_nxt = w_cond;
                end
            end
            StResolve: begin
                w_state_nxt = StIdle;
                if (r_taken) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_flags <= 3'b000;
            r_taken <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_flags <= w_flags_nxt;
            r_taken <= w_taken_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign br_ready  = (r_state == StIdle);
    assign br_done   = (r_state == StResolve);
    assign br_taken  = br_done & r_taken;
    assign flags     = r_flags;
    assign taken_cnt = r_cnt;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: two instances (FWD=1/CNT_W=16 and FWD=0/CNT_W=4) driven alike
// and checked each cycle against a behavioural model, plus literal directed expectations.
module tb_flag_branch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [2:0]  alu_ops = 3'b000;
    logic [15:0] alu_dst = 16'h0000;
    logic        alu_ov = 1'b0;
    logic        alu_zr = 1'b0;
    logic        br_req = 1'b0;
    logic [2:0]  br_ccc = 3'b000;

    logic        ready0, done0, taken0;
    logic [2:0]  flags0;
    logic [15:0] cnt0;
    logic        ready1, done1, taken1;
    logic [2:0]  flags1;
    logic [3:0]  cnt1;

    int total = 0;
    int bad = 0;
    bit checking = 1'b0;

    always #5 clk = ~clk;

    flag_branch_unit #(.FWD(1'b1), .CNT_W(16)) u_fwd (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_ops(alu_ops),
        .alu_dst(alu_dst), .alu_ov(alu_ov), .alu_zr(alu_zr), .br_req(br_req),
        .br_ccc(br_ccc), .br_ready(ready0), .br_done(done0), .br_taken(taken0),
        .flags(flags0), .taken_cnt(cnt0)
    );

    flag_branch_unit #(.FWD(1'b0), .CNT_W(4)) u_nofwd (
        .clk(clk), .rst_n(rst_n), .alu_valid(alu_valid), .alu_ops(alu_ops),
        .alu_dst(alu_dst), .alu_ov(alu_ov), .alu_zr(alu_zr), .br_req(br_req),
        .br_ccc(br_ccc), .br_ready(ready1), .br_done(done1), .br_taken(taken1),
        .flags(flags1), .taken_cnt(cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_flags [2];
    bit          m_busy  [2];
    bit          m_res   [2];
    int unsigned m_cnt   [2];
    int unsigned m_mod   [2] = '{65536, 16};

    function automatic logic [2:0] upd(input logic [2:0] f);
        if (!alu_valid || alu_ops == 3'd6) return f;
        if (alu_ops <= 3'd1) return {alu_zr, alu_ov, alu_dst[15]};
        return {alu_zr, f[1:0]};
    endfunction

    function automatic bit cond(input logic [2:0] f, input logic [2:0] c);
        bit z = f[2];
        bit v = f[1];
        bit n = f[0];
        bit t [8];
        t = '{!z, z, !z && !n, n, z || !n, n || z, v, 1'b1};
        return t[c];
    endfunction

    initial begin
        logic [2:0] nf;
        forever begin
            @(posedge clk or negedge rst_n);
            for (int i = 0; i < 2; i++) begin
                if (!rst_n) begin
                    m_flags[i] = 3'b000;
                    m_busy[i]  = 1'b0;
                    m_res[i]   = 1'b0;
                    m_cnt[i]   = 0;
                end else begin
                    nf = upd(m_flags[i]);
                    if (m_busy[i]) begin
                        if (m_res[i]) m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
                        m_busy[i] = 1'b0;
                    end else if (br_req) begin
                        m_busy[i] = 1'b1;
                        m_res[i]  = cond((i == 0) ? nf : m_flags[i], br_ccc);
                    end
                    m_flags[i] = nf;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (checking && rst_n) begin
            chk("ready0", {31'd0, ready0}, {31'd0, !m_busy[0]});
            chk("done0",  {31'd0, done0},  {31'd0, m_busy[0]});
            chk("taken0", {31'd0, taken0}, {31'd0, m_busy[0] && m_res[0]});
            chk("flags0", {29'd0, flags0}, {29'd0, m_flags[0]});
            chk("cnt0",   {16'd0, cnt0},   m_cnt[0]);
            chk("ready1", {31'd0, ready1}, {31'd0, !m_busy[1]});
            chk("done1",  {31'd0, done1},  {31'd0, m_busy[1]});
            chk("taken1", {31'd0, taken1}, {31'd0, m_busy[1] && m_res[1]});
            chk("flags1", {29'd0, flags1}, {29'd0, m_flags[1]});
            chk("cnt1",   {28'd0, cnt1},   m_cnt[1]);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic alu(input logic [2:0] op, input logic [15:0] dst, input logic ov,
                       input logic zr);
        alu_valid = 1'b1;
        alu_ops   = op;
        alu_dst   = dst;
        alu_ov    = ov;
        alu_zr    = zr;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic branch(input logic [2:0] ccc, input logic exp_taken);
        br_req = 1'b1;
        br_ccc = ccc;
        @(negedge clk);
        br_req = 1'b0;
        chk("br_done_pulse", {31'd0, done0}, 32'd1);
        chk("br_taken_dir", {31'd0, taken0}, {31'd0, exp_taken});
        @(negedge clk);
        chk("br_done_single", {31'd0, done0}, 32'd0);
    endtask

    // Async reset pulse in the low phase, away from any rising edge.
    task automatic reset_pulse(input bit pin);
        #1 rst_n = 1'b0;
        #1;
        if (pin) begin
            chk("rst_flags", {29'd0, flags0}, 32'd0);
            chk("rst_ready", {31'd0, ready0}, 32'd1);
            chk("rst_done0", {31'd0, done0}, 32'd0);
            chk("rst_done1", {31'd0, done1}, 32'd0);
            chk("rst_cnt", {16'd0, cnt0}, 32'd0);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int pulses;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        checking = 1'b1;
        chk("init_ready", {31'd0, ready0}, 32'd1);
        chk("init_cnt", {16'd0, cnt0}, 32'd0);

        // add: Z=0 V=1 N=1; and with zr=1 sets Z only; lhb changes nothing
        alu(3'b000, 16'h8000, 1'b1, 1'b0);
        chk("flags_add", {29'd0, flags0}, 32'b011);
        alu(3'b010, 16'h0000, 1'b0, 1'b1);
        chk("flags_and", {29'd0, flags0}, 32'b111);
        alu(3'b110, 16'h0000, 1'b0, 1'b0);
        chk("flags_lhb", {29'd0, flags0}, 32'b111);
        reset_pulse(1'b1);
        @(negedge clk);

        alu(3'b000, 16'h0000, 1'b0, 1'b0);
        chk("flags_clear", {29'd0, flags0}, 32'b000);
        branch(3'b010, 1'b1);
        branch(3'b011, 1'b0);
        branch(3'b111, 1'b1);
        chk("cnt_two", {16'd0, cnt0}, 32'd2);

        // Same-cycle sub with zr=1 and EQ branch from committed Z=0
        alu_valid = 1'b1; alu_ops = 3'b001; alu_dst = 16'h0000; alu_ov = 1'b0; alu_zr = 1'b1;
        br_req = 1'b1; br_ccc = 3'b001;
        @(negedge clk);
        alu_valid = 1'b0; br_req = 1'b0;
        chk("fwd1_taken", {31'd0, taken0}, 32'd1);
        chk("fwd0_taken", {31'd0, taken1}, 32'd0);
        @(negedge clk);

        // Held UNCOND request: 34 edges give 17 resolves; 4-bit counter wraps to 1
        reset_pulse(1'b0);
        pulses = 0;
        br_req = 1'b1; br_ccc = 3'b111;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (done0) pulses++;
        end
        br_req = 1'b0;
        chk("held_pulses", pulses, 32'd17);
        chk("cnt16_17", {16'd0, cnt0}, 32'd17);
        chk("cnt4_wrap", {28'd0, cnt1}, 32'd1);

        // Reset while resolving a taken branch
        reset_pulse(1'b0);
        br_req = 1'b1; br_ccc = 3'b111;
        @(negedge clk);
        br_req = 1'b0;
        chk("pre_rst_done", {31'd0, done0}, 32'd1);
        reset_pulse(1'b1);
        @(negedge clk);
        chk("post_rst_cnt", {16'd0, cnt0}, 32'd0);
        chk("post_rst_done", {31'd0, done0}, 32'd0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            alu_valid = 1'($urandom_range(0, 1));
            alu_ops   = 3'($urandom_range(0, 7));
            alu_dst   = 16'($urandom);
            alu_ov    = 1'($urandom_range(0, 1));
            alu_zr    = 1'($urandom_range(0, 1));
            br_req    = 1'($urandom_range(0, 1));
            br_ccc    = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 199) == 0) reset_pulse(1'b0);
            @(negedge clk);
        end
        alu_valid = 1'b0;
        br_req = 1'b0;
        @(negedge clk);
        checking = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
